// File: rtl/cam_trig_pkg.sv
// Shared types and default timing constants for the camera trigger generator.
// State encoding is fixed so status readout tools can decode it directly.
package cam_trig_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DELAY    = 2'd1,
        PULSE    = 2'd2,
        WAIT_RDY = 2'd3
    } state_t;

    localparam int          DROP_W              = 8;
    localparam int          TRIG_DELAY_DEF      = 16;
    localparam int          PULSE_LEN_DEF       = 1000;
    localparam int          RDY_SYNC_STAGES_DEF = 2;
    localparam int          CNT_W_DEF           = 16;
    localparam logic [23:0] TIMEOUT_CYC_DEF     = 24'd2_000_000;

    // Saturating increment for the dropped-trigger counter.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cam_trig_gen_if.sv
// Pipe/camera-side bundle of cam_trig_gen: trigger request, camera handshake and status.
// master = pixel pipe / camera side, slave = cam_trig_gen.
interface cam_trig_gen_if #(
    parameter int CNT_W = 16
);

    logic                             trig_in;
    logic                             f_frm;
    logic                             cam_rdy_async;
    logic                             cam_trig;
    logic                             rdy_pulse;
    logic                             busy;
    logic                             seq_start;
    logic [CNT_W-1:0]                 frame_cnt;
    logic [cam_trig_pkg::DROP_W-1:0]  drop_cnt;
    logic                             timeout;

    modport master (
        output trig_in, f_frm, cam_rdy_async,
        input  cam_trig, rdy_pulse, busy, seq_start, frame_cnt, drop_cnt, timeout
    );

    modport slave (
        input  trig_in, f_frm, cam_rdy_async,
        output cam_trig, rdy_pulse, busy, seq_start, frame_cnt, drop_cnt, timeout
    );

endinterface

// File: rtl/cam_trig_gen_sync_edge.sv
// sync_edge: multi-stage synchroniser for an asynchronous GPIO with a registered
// rising-edge pulse that is masked for STAGES+1 cycles after reset release.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    localparam int                MASK_W    = $clog2(STAGES + 2);
    localparam logic [MASK_W-1:0] MASK_INIT = MASK_W'(STAGES + 1);

    logic [STAGES-1:0] sync_q;
    logic              synced_q;
    logic [MASK_W-1:0] mask_cnt;

    // NOTE: state is updated with non-blocking assignments so every flop in the chain
    // samples its pre-edge neighbour; blocking here would collapse the synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            synced_q <= 1'b0;
            mask_cnt <= MASK_INIT;
            rise     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[STAGES-2:0], din};
            synced_q <= sync_q[STAGES-1];
            rise     <= sync_q[STAGES-1] & ~synced_q & (mask_cnt == '0);
            if (mask_cnt != '0) begin
                mask_cnt <= mask_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_trig_gen.sv
// Camera trigger generator: delayed fixed-length cam_trig per accepted trigger, then waits for camera ready.
// Optional feature macro CAM_TRIG_TIMEOUT_EN: abandon WAIT_RDY after TIMEOUT_CYC cycles and set sticky timeout.
module cam_trig_gen
    import cam_trig_pkg::*;
#(
    parameter int          TRIG_DELAY      = TRIG_DELAY_DEF,
    parameter int          PULSE_LEN       = PULSE_LEN_DEF,
    parameter int          RDY_SYNC_STAGES = RDY_SYNC_STAGES_DEF,
    parameter int          CNT_W           = CNT_W_DEF,
    parameter logic [23:0] TIMEOUT_CYC     = TIMEOUT_CYC_DEF
) (
    input logic           clk,
    input logic           rst,
    cam_trig_gen_if.slave bus
);

    // One shared down-counter serves both DELAY and PULSE; it only ever holds load-1 values.
    localparam int               TMR_MAX    = (TRIG_DELAY > PULSE_LEN) ? TRIG_DELAY : PULSE_LEN;
    localparam int               TMR_W      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'((TRIG_DELAY > 0) ? TRIG_DELAY - 1 : 0);
    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_LEN - 1);

    state_t            state, state_n;
    logic [TMR_W-1:0]  tmr, tmr_n;
    logic              trig_q, trig_edge, accept, rdy_rise, tout_hit;
    logic              cam_trig_q, seq_start_q, timeout_q;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic [DROP_W-1:0] drop_cnt_q;

    sync_edge #(.STAGES(RDY_SYNC_STAGES)) u_rdy_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.cam_rdy_async),
        .rise (rdy_rise)
    );

    assign trig_edge = bus.trig_in & ~trig_q;

`ifdef CAM_TRIG_TIMEOUT_EN
    logic [23:0] tout_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != WAIT_RDY) tout_cnt <= '0;
        else                          tout_cnt <= tout_cnt + 1'b1;
    end

    assign tout_hit = (state == WAIT_RDY) && (tout_cnt == TIMEOUT_CYC - 24'd1);
`else
    assign tout_hit = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no branch can leave it
    // unassigned and infer a latch.
    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (trig_edge) begin
                    accept = 1'b1;
                    if (TRIG_DELAY == 0) begin
                        state_n = PULSE;
                        tmr_n   = PULSE_LOAD;
                    end else begin
                        state_n = DELAY;
                        tmr_n   = DELAY_LOAD;
                    end
                end
            end
            DELAY: begin
                if (tmr == '0) begin
                    state_n = PULSE;
                    tmr_n   = PULSE_LOAD;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            PULSE: begin
                if (tmr == '0) state_n = WAIT_RDY;
                else           tmr_n   = tmr - 1'b1;
            end
            WAIT_RDY: begin
                if (rdy_rise || tout_hit) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tmr         <= '0;
            trig_q      <= 1'b1;
            cam_trig_q  <= 1'b0;
            seq_start_q <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state       <= state_n;
            tmr         <= tmr_n;
            trig_q      <= bus.trig_in;
            cam_trig_q  <= (state_n == PULSE);
            seq_start_q <= accept & bus.f_frm;
            if (accept) begin
                frame_cnt_q <= bus.f_frm ? CNT_W'(1) : frame_cnt_q + 1'b1;
            end
            if (trig_edge && state != IDLE) begin
                drop_cnt_q <= sat_inc(drop_cnt_q);
            end
            if (tout_hit && !rdy_rise) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.cam_trig  = cam_trig_q;
    assign bus.rdy_pulse = rdy_rise;
    assign bus.busy      = (state != IDLE);
    assign bus.seq_start = seq_start_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.timeout   = timeout_q;

endmodule
